// File: rtl/packed_lane_pkg.sv
// Shared types and helpers for the packed-lane datapath: FSM state encoding,
// the MSB-lane-0 lane extraction rule and the part-select range check.
package packed_lane_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Default geometry of the packed words used across this codebase.
  localparam int PKG_LANES = 4;
  localparam int PKG_WIDTH = 8;

  // Lane 0 occupies the most significant WIDTH bits of the flat word.
  function automatic logic [PKG_WIDTH-1:0] lane_sel(
    input logic [PKG_LANES*PKG_WIDTH-1:0] word,
    input int unsigned                    idx
  );
    return word[(PKG_LANES-1-idx)*PKG_WIDTH +: PKG_WIDTH];
  endfunction

  // Ascending mirrors `+:` (base..base+count-1), descending mirrors `-:`
  // (base..base-count+1); both must stay inside 0..lanes-1 without wrapping.
  function automatic logic range_ok(
    input int unsigned base,
    input int unsigned count,
    input logic        dir,
    input int unsigned lanes
  );
    if (count == 0) return 1'b0;
    if (dir) return count <= base + 1;
    return base + count <= lanes;
  endfunction

endpackage

// File: rtl/packed_lane_mux.sv
// Combinational LANES:1 lane selector over a flat packed word, lane 0 in the
// most significant position.
module packed_lane_mux #(
  parameter  int LANES = 4,
  parameter  int WIDTH = 8,
  localparam int IW    = $clog2(LANES)
) (
  input  logic [LANES*WIDTH-1:0] word,
  input  logic [IW-1:0]          idx,
  output logic [WIDTH-1:0]       lane
);

  always_comb begin
    lane = '0;
    for (int i = 0; i < LANES; i++) begin
      if (idx == IW'(i)) lane = word[(LANES-1-i)*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/packed_lane_sequencer.sv
// Emits a run-time `+:` / `-:` part-select of a packed multi-lane word as a
// stream of single lanes, one per output handshake.
module packed_lane_sequencer
  import packed_lane_pkg::*;
#(
  parameter  int LANES = 4,
  parameter  int WIDTH = 8,
  localparam int IW    = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [IW-1:0]          in_base,
  input  logic [IW:0]            in_count,
  input  logic                   in_dir,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_lane,
  output logic [IW-1:0]          out_index,
  output logic                   out_last,
  output logic                   busy,
  output logic                   err,
  output state_t                 state_dbg
);

  // Handshake contract (both sides): a transfer happens on a rising clk edge
  // where valid && ready; once valid is high it holds, together with its
  // payload, until that transfer. ready never depends combinationally on the
  // other side's valid or ready.

  state_t                 state_q, state_d;
  logic                   in_ready_q, err_q;
  logic                   out_valid_q, out_last_q;
  logic [LANES*WIDTH-1:0] data_q;
  logic [IW-1:0]          idx_q, step_idx, mux_idx;
  logic [IW:0]            rem_q;
  logic                   dir_q;
  logic [WIDTH-1:0]       out_lane_q, mux_lane;
  logic [LANES*WIDTH-1:0] mux_word;
  logic                   accept, req_ok, fire;

  assign accept   = (state_q == IDLE) && in_valid && in_ready_q;
  assign req_ok   = range_ok(32'(in_base), 32'(in_count), in_dir, LANES);
  assign fire     = out_valid_q && out_ready;
  assign step_idx = dir_q ? idx_q - IW'(1) : idx_q + IW'(1);

  // One selector serves both the first lane (from the live request) and every
  // later lane (from the captured copy at the stepped index).
  assign mux_word = (state_q == IDLE) ? in_data : data_q;
  assign mux_idx  = (state_q == IDLE) ? in_base : step_idx;

  packed_lane_mux #(.LANES(LANES), .WIDTH(WIDTH)) u_mux (
    .word (mux_word),
    .idx  (mux_idx),
    .lane (mux_lane)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && req_ok) state_d = SEND;
      SEND:    if (fire && out_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_lane_q  <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      dir_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Ready only after a full IDLE cycle, which leaves one bubble after completion.
      in_ready_q <= (state_q == IDLE) && (state_d == IDLE);
      err_q      <= accept && !req_ok;
      if (accept && req_ok) begin
        data_q      <= in_data;
        idx_q       <= in_base;
        rem_q       <= in_count;
        dir_q       <= in_dir;
        out_valid_q <= 1'b1;
        out_last_q  <= (in_count == (IW+1)'(1));
        out_lane_q  <= mux_lane;
      end else if (fire) begin
        if (out_last_q) begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end else begin
          idx_q      <= step_idx;
          rem_q      <= rem_q - (IW+1)'(1);
          out_last_q <= (rem_q == (IW+1)'(2));
          out_lane_q <= mux_lane;
        end
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_lane  = out_lane_q;
  assign out_index = idx_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == SEND);
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_packed_lane_sequencer.sv
// Self-checking bench for packed_lane_sequencer: scenario tasks plus a lane
// scoreboard that compares every output handshake against an expected queue.
module tb_packed_lane_sequencer;

  localparam int LANES = 4;
  localparam int WIDTH = 8;
  localparam int IW    = 2;
  localparam int EW    = IW + WIDTH + 1;

  logic                   clk, rst_n;
  logic                   in_valid, in_ready, in_dir;
  logic [LANES*WIDTH-1:0] in_data;
  logic [IW-1:0]          in_base, out_index;
  logic [IW:0]            in_count;
  logic                   out_valid, out_ready, out_last, busy, err;
  logic [WIDTH-1:0]       out_lane;
  packed_lane_pkg::state_t state_dbg;

  logic [EW-1:0] exp_q[$];
  int            checks, fails, hs_count;
  logic          stall_prev;
  logic [EW-1:0] prev_out;

  packed_lane_sequencer #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_base   (in_base),
    .in_count  (in_count),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lane  (out_lane),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: sim time %0t exceeded, required completion earlier", $time);
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || {out_index, out_lane, out_last} !== prev_out) begin
          fails++;
          $display("FAIL stall_hold: got v=%b %h required v=1 %h", out_valid,
                   {out_index, out_lane, out_last}, prev_out);
        end
      end
      if (out_valid && out_ready) begin
        hs_count++;
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL lane_unexpected: got idx=%0d lane=%h last=%b required no output",
                   out_index, out_lane, out_last);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          if ({out_index, out_lane, out_last} !== e) begin
            fails++;
            $display("FAIL lane_data: got idx=%0d lane=%h last=%b required idx=%0d lane=%h last=%b",
                     out_index, out_lane, out_last, e[EW-1 -: IW], e[WIDTH:1], e[0]);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_out   = {out_index, out_lane, out_last};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_expected(input logic [31:0] data, input int base, input int count,
                               input logic dir);
    logic ok;
    int   idx;
    logic [WIDTH-1:0] lane;
    ok = (count >= 1) && (dir ? (count <= base + 1) : (base + count <= LANES));
    if (ok) begin
      for (int k = 0; k < count; k++) begin
        idx  = dir ? base - k : base + k;
        lane = data[(LANES-1-idx)*WIDTH +: WIDTH];
        exp_q.push_back({IW'(idx), lane, (k == count - 1)});
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] data, input int base, input int count,
                       input logic dir);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      cycle();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready: in_ready=%b required 1 within 50 cycles", in_ready);
    end
    in_data  = data;
    in_base  = IW'(base);
    in_count = (IW+1)'(count);
    in_dir   = dir;
    in_valid = 1'b1;
    push_expected(data, base, count, dir);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 100) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL wait_idle: pending=%0d busy=%b required 0 and 0", exp_q.size(), busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_base = '0; in_count = '0;
    in_dir = 1'b0; out_ready = 1'b0;
    repeat (3) cycle();
    checks++;
    if ({in_ready, out_valid, out_lane, out_index, out_last, busy, err} !== '0) begin
      fails++;
      $display("FAIL reset_values: got rdy=%b v=%b lane=%h idx=%0d last=%b busy=%b err=%b required all 0",
               in_ready, out_valid, out_lane, out_index, out_last, busy, err);
    end
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_ready0: in_ready=%b required 0", in_ready);
    end
    cycle();
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready1: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_ascending();
    out_ready = 1'b1;
    issue(32'h11223344, 1, 2, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_index !== 2'd1 || out_lane !== 8'h22 || out_last !== 1'b0) begin
      fails++;
      $display("FAIL asc_first: v=%b idx=%0d lane=%h last=%b required 1 1 22 0",
               out_valid, out_index, out_lane, out_last);
    end
    cycle();
    checks++;
    if (out_index !== 2'd2 || out_lane !== 8'h33 || out_last !== 1'b1) begin
      fails++;
      $display("FAIL asc_second: idx=%0d lane=%h last=%b required 2 33 1", out_index, out_lane, out_last);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL asc_done: v=%b busy=%b required 0 0", out_valid, busy);
    end
    cycle();
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL asc_ready_back: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_descending();
    out_ready = 1'b1;
    issue(32'h11223344, 1, 2, 1'b1);
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic pat[7];
    int   hs0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    hs0 = hs_count;
    issue(32'h11223344, 0, 4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      cycle();
    end
    out_ready = 1'b1;
    repeat (3) cycle();
    checks++;
    if (hs_count - hs0 != 4 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_handshakes: got %0d v=%b required 4 v=0", hs_count - hs0, out_valid);
    end
    wait_idle();
  endtask

  task automatic test_invalid();
    int cases[3][3];
    cases = '{'{3, 2, 0}, '{0, 2, 1}, '{0, 0, 0}};
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      issue(32'hA1B2C3D4, cases[c][0], cases[c][1], cases[c][2][0]);
      checks++;
      if (err !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL invalid_%0d: err=%b v=%b rdy=%b required 1 0 1", c, err, out_valid, in_ready);
      end
      cycle();
      checks++;
      if (err !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL invalid_pulse_%0d: err=%b v=%b required 0 0", c, err, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b1;
    issue(32'hDEADBEEF, 0, 4, 1'b0);
    in_data  = 32'h5566_7788;
    in_base  = 2'd3;
    in_count = 3'd2;
    in_dir   = 1'b1;
    in_valid = 1'b1;
    push_expected(32'h5566_7788, 3, 2, 1'b1);
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      checks++;
      if (busy === 1'b1 && in_ready !== 1'b0) begin
        fails++;
        $display("FAIL guard_ready: in_ready=%b while busy, required 0", in_ready);
      end
      cycle();
      n++;
    end
    checks++;
    if (n < 4) begin
      fails++;
      $display("FAIL guard_early: ready after %0d cycles, required at least 4", n);
    end
    cycle();
    in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    issue(32'h0A0B0C0D, 0, 4, 1'b0);
    cycle();
    cycle();
    checks++;
    if (out_index !== 2'd2 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_index: idx=%0d v=%b required 2 1", out_index, out_valid);
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_index !== '0) begin
      fails++;
      $display("FAIL mid_async: v=%b busy=%b rdy=%b idx=%0d required 0 0 0 0",
               out_valid, busy, in_ready, out_index);
    end
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_release: rdy=%b v=%b required 1 0", in_ready, out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL mid_no_lanes: v=%b at cycle %0d required 0", out_valid, i);
      end
    end
  endtask

  task automatic test_random();
    int b, c;
    logic d;
    logic [31:0] w;
    for (int t = 0; t < 12; t++) begin
      b = $urandom_range(0, LANES - 1);
      c = $urandom_range(0, LANES);
      d = 1'($urandom_range(0, 1));
      w = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      issue(w, b, c, d);
      while (busy === 1'b1) begin
        out_ready = 1'($urandom_range(0, 1));
        cycle();
      end
      out_ready = 1'b1;
      wait_idle();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0; fails = 0; hs_count = 0; stall_prev = 1'b0; prev_out = '0;
    test_reset();
    test_ascending();
    test_descending();
    test_backpressure();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) cycle();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL final_queue: %0d lanes pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
